// File: rtl/morse_stream_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : morse_stream_decoder                                          |
// | Brief    : Single-key Morse receiver producing (length, pattern) tokens  |
// |            into a FIFO drained over valid/ready. Optional word-space     |
// |            tokens are enabled with the WORD_SPACE_EN macro.              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module morse_stream_decoder #(
    parameter int UNIT_CYCLES = 5000000,
    parameter int MIN_PRESS   = 1000,
    parameter int MAX_SYM     = 10,
    parameter int DEPTH       = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         key_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(MAX_SYM+1)-1:0] out_len,
    output logic [MAX_SYM-1:0]           out_code,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         key_level,
    output logic                         sym_err,
    output logic                         ovf
);

    localparam int c_lw = $clog2(MAX_SYM+1);
    localparam int c_cw = $clog2(7*UNIT_CYCLES+1);
    localparam int c_pw = $clog2(DEPTH);
    localparam int c_fw = $clog2(DEPTH+1);

    localparam logic [c_cw-1:0] c_one       = c_cw'(1);
    localparam logic [c_cw-1:0] c_min_press = c_cw'(MIN_PRESS);
    localparam logic [c_cw-1:0] c_dash_cnt  = c_cw'(2*UNIT_CYCLES);
    localparam logic [c_cw-1:0] c_gap_cnt   = c_cw'(3*UNIT_CYCLES);
    localparam logic [c_cw-1:0] c_max_cnt   = c_cw'(7*UNIT_CYCLES);
    localparam logic [c_lw-1:0] c_max_len   = c_lw'(MAX_SYM);
    localparam logic [c_fw-1:0] c_depth     = c_fw'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2,
        S_WGAP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and edge detection
    // ------------------------------------------------------------------
    logic r_sync1, r_sync2, r_key_d;
    logic w_rise, w_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_key_d <= 1'b0;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
            r_key_d <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_key_d;
    assign w_fall = ~r_sync2 & r_key_d;

    // ------------------------------------------------------------------
    // Character FSM and duration counter
    // ------------------------------------------------------------------
    state_t              r_state, w_state;
    state_t              r_prior, w_prior;
    logic [c_cw-1:0]     r_cnt, w_cnt;
    logic [c_cw-1:0]     r_saved, w_saved;
    logic [c_lw-1:0]     r_len, w_len;
    logic [MAX_SYM-1:0]  r_code, w_code;
    logic                r_discard, w_discard;
    logic                r_sym_err, w_sym_err;
    logic                r_key_level;

    logic [c_cw-1:0]     w_cnt_inc;
    logic [c_cw:0]       w_sum;
    logic [c_cw-1:0]     w_restore;
    logic                w_dash;
    logic                w_push;
    logic [c_lw-1:0]     w_push_len;
    logic [MAX_SYM-1:0]  w_push_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_prior     <= S_IDLE;
            r_cnt       <= '0;
            r_saved     <= '0;
            r_len       <= '0;
            r_code      <= '0;
            r_discard   <= 1'b0;
            r_sym_err   <= 1'b0;
            r_key_level <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_prior     <= w_prior;
            r_cnt       <= w_cnt;
            r_saved     <= w_saved;
            r_len       <= w_len;
            r_code      <= w_code;
            r_discard   <= w_discard;
            r_sym_err   <= w_sym_err;
            r_key_level <= (w_state == S_PRESS) && (w_cnt >= c_min_press);
        end
    end

    always_comb begin
        w_cnt_inc   = (r_cnt < c_max_cnt) ? r_cnt + c_one : r_cnt;
        // A glitch resumes the interrupted gap as if the key never moved.
        w_sum       = {1'b0, r_saved} + {1'b0, r_cnt};
        w_restore   = (w_sum > {1'b0, c_max_cnt}) ? c_max_cnt : w_sum[c_cw-1:0];
        w_dash      = (r_cnt >= c_dash_cnt);

        w_state     = r_state;
        w_prior     = r_prior;
        w_cnt       = w_cnt_inc;
        w_saved     = r_saved;
        w_len       = r_len;
        w_code      = r_code;
        w_discard   = r_discard;
        w_sym_err   = 1'b0;
        w_push      = 1'b0;
        w_push_len  = r_len;
        w_push_code = r_code;

        if ((r_state != S_PRESS) && w_rise) begin
            w_state = S_PRESS;
            w_prior = r_state;
            w_saved = r_cnt;
            w_cnt   = c_one;
        end else begin
            case (r_state)
                S_PRESS: begin
                    if (w_fall) begin
                        if (r_cnt < c_min_press) begin
                            w_state = r_prior;
                            w_cnt   = w_restore;
                        end else begin
                            w_state = S_GAP;
                            w_cnt   = c_one;
                            if (!r_discard) begin
                                if (r_len == c_max_len) begin
                                    w_sym_err = 1'b1;
                                    w_discard = 1'b1;
                                end else begin
                                    w_code    = r_code << 1;
                                    w_code[0] = w_dash;
                                    w_len     = r_len + c_lw'(1);
                                end
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (w_cnt_inc >= c_gap_cnt) begin
                        w_push    = ~r_discard;
                        w_len     = '0;
                        w_code    = '0;
                        w_discard = 1'b0;
                        w_state   = S_WGAP;
                    end
                end
                S_WGAP: begin
                    if (w_cnt_inc >= c_max_cnt) begin
`ifdef WORD_SPACE_EN
                        w_push      = 1'b1;
                        w_push_len  = '0;
                        w_push_code = '0;
`endif
                        w_state = S_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Token FIFO with registered head outputs
    // ------------------------------------------------------------------
    logic [c_lw-1:0]    r_mem_len  [DEPTH];
    logic [MAX_SYM-1:0] r_mem_code [DEPTH];
    logic [c_pw-1:0]    r_wr_ptr, r_rd_ptr, w_rd_next;
    logic [c_fw-1:0]    r_count, w_count;
    logic               r_valid, r_ovf;
    logic [c_lw-1:0]    r_head_len, w_head_len;
    logic [MAX_SYM-1:0] r_head_code, w_head_code;
    logic               w_pop, w_full, w_wr_en, w_drop;

    always_comb begin
        w_pop     = r_valid & out_ready;
        w_full    = (r_count == c_depth);
        w_wr_en   = w_push & (~w_full | w_pop);
        w_drop    = w_push & w_full & ~w_pop;
        w_rd_next = w_pop ? r_rd_ptr + c_pw'(1) : r_rd_ptr;

        w_count = r_count;
        if (w_wr_en && !w_pop) begin
            w_count = r_count + c_fw'(1);
        end else if (!w_wr_en && w_pop) begin
            w_count = r_count - c_fw'(1);
        end

        // The incoming token becomes head when it lands in the next read slot.
        w_head_len  = '0;
        w_head_code = '0;
        if (w_count != '0) begin
            if (w_wr_en && (w_rd_next == r_wr_ptr)) begin
                w_head_len  = w_push_len;
                w_head_code = w_push_code;
            end else begin
                w_head_len  = r_mem_len[w_rd_next];
                w_head_code = r_mem_code[w_rd_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_len[r_wr_ptr]  <= w_push_len;
            r_mem_code[r_wr_ptr] <= w_push_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_head_len  <= '0;
            r_head_code <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_pw'(1);
            end
            r_rd_ptr    <= w_rd_next;
            r_count     <= w_count;
            r_valid     <= (w_count != '0);
            r_head_len  <= w_head_len;
            r_head_code <= w_head_code;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_len    = r_head_len;
    assign out_code   = r_head_code;
    assign fifo_count = r_count;
    assign key_level  = r_key_level;
    assign sym_err    = r_sym_err;
    assign ovf        = r_ovf;

endmodule
`default_nettype wire
